// File: rtl/uart_word_buffer.sv
// uart_word_buffer
// ----------------
// Sits between the UART receiver/transmitter and the encoder/decoder
// datapath.
//
// RX path: received bytes are packed LSB-first into NUM_BYTES-byte words.
// Each completed word is queued in a DEPTH-entry FIFO. The consumer reads
// the FIFO through a valid/ready handshake. If a word completes while the
// FIFO is full and nothing is popped in that cycle, the word is dropped and
// the sticky overflow flag is set.
//
// TX path: a word is taken from a valid/ready producer and sent byte 0
// first to the UART transmitter. Each start pulse is paced on the
// transmitter's busy flag.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   clear               synchronous flush of both paths and overflow
//   rx_valid, rx_byte   one-cycle byte strobe from the receiver
//   word_out/valid/ready  FIFO head word and its handshake
//   fifo_count          words currently stored (0..DEPTH)
//   byte_count          bytes held in the partial word (0..NUM_BYTES-1)
//   overflow            sticky: a completed word was dropped
//   tx_word/valid/ready word handshake from the producer
//   tx_busy             transmitter busy flag
//   tx_start, tx_data   start pulse and byte to the transmitter

module uart_word_buffer #(
    parameter int NUM_BYTES = 4,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_byte,
    output logic [8*NUM_BYTES-1:0]       word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic [$clog2(NUM_BYTES):0]   byte_count,
    output logic                         overflow,
    input  logic [8*NUM_BYTES-1:0]       tx_word,
    input  logic                         tx_word_valid,
    output logic                         tx_word_ready,
    input  logic                         tx_busy,
    output logic                         tx_start,
    output logic [7:0]                   tx_data
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(NUM_BYTES) + 1;

    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_FREE,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    // ------------------------------------------------------------------
    // RX packing
    // ------------------------------------------------------------------
    logic [W-1:0]  pack_reg;
    logic [W-1:0]  assembled;
    logic          last_byte;
    logic          push_req;
    logic          push_do;
    logic          pop;
    logic          full;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // The incoming byte is merged into its lane combinationally.
    // This lets the word that completes on the last byte be pushed into
    // the FIFO in the same cycle the byte arrives.
    always_comb begin
        assembled = pack_reg;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (byte_count == BW'(k)) begin
                assembled[8*k +: 8] = rx_byte;
            end
        end
    end

    assign last_byte = (byte_count == LAST_BYTE);
    assign full      = (fifo_count == FULL_CNT);
    assign word_valid = (fifo_count != '0);

    // clear wins over any same-cycle byte or pop.
    // A full FIFO still accepts a push when a pop happens in the same
    // cycle, because that pop frees the slot.
    assign push_req = rx_valid && last_byte && !clear;
    assign pop      = word_valid && word_ready && !clear;
    assign push_do  = push_req && (!full || pop);

    // Byte lane counter and partial-word register.
    // When a word completes, byte_count returns to zero even if the word
    // is dropped on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count <= '0;
            pack_reg   <= '0;
        end else if (clear) begin
            byte_count <= '0;
        end else if (rx_valid) begin
            pack_reg   <= assembled;
            byte_count <= last_byte ? '0 : byte_count + 1'b1;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_do) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_do, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Word storage needs no reset.
    // An entry is only visible after it has been written.
    always_ff @(posedge clk) begin
        if (push_do) begin
            mem[wr_ptr] <= assembled;
        end
    end

    assign word_out = word_valid ? mem[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------
    tx_state_t     state;
    tx_state_t     next_state;
    logic [W-1:0]  shift_reg;
    logic [BW-1:0] tx_idx;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // Each byte passes through three steps:
    //   1. Wait for the transmitter to be free, then fire tx_start.
    //   2. Wait until the transmitter shows busy.
    //   3. Wait until busy drops again.
    // Waiting for busy to rise prevents a second start pulse from being
    // fired before the transmitter has reacted to the first one.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = TX_IDLE;
        end else begin
            case (state)
                TX_IDLE:      if (tx_word_valid) next_state = TX_WAIT_FREE;
                TX_WAIT_FREE: if (!tx_busy)      next_state = TX_WAIT_BUSY;
                TX_WAIT_BUSY: if (tx_busy)       next_state = TX_WAIT_DONE;
                TX_WAIT_DONE: begin
                    if (!tx_busy) begin
                        next_state = (tx_idx == LAST_BYTE) ? TX_IDLE : TX_WAIT_FREE;
                    end
                end
                default:      next_state = TX_IDLE;
            endcase
        end
    end

    // Output logic.
    // Both outputs are gated by clear.
    // This stops a flushed cycle from looking like an accepted word or a
    // start pulse.
    always_comb begin
        tx_word_ready = (state == TX_IDLE) && !clear;
        tx_start      = (state == TX_WAIT_FREE) && !tx_busy && !clear;
    end

    // Shift register and byte index.
    // tx_data is loaded before entering TX_WAIT_FREE, so it already holds
    // the correct byte when tx_start fires. It then stays put until the
    // next byte is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            tx_idx    <= '0;
            tx_data   <= '0;
        end else if (clear) begin
            tx_idx    <= '0;
        end else if (state == TX_IDLE && tx_word_valid) begin
            tx_data   <= tx_word[7:0];
            shift_reg <= tx_word >> 8;
            tx_idx    <= '0;
        end else if (state == TX_WAIT_DONE && !tx_busy && tx_idx != LAST_BYTE) begin
            tx_data   <= shift_reg[7:0];
            shift_reg <= shift_reg >> 8;
            tx_idx    <= tx_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_word_buffer.sv
// tb_uart_word_buffer
// -------------------
// Bench for uart_word_buffer.
//
// The main instance uses the default 4-byte / 4-deep build.
// A second instance uses a 1-byte / 2-deep build.
//
// Expected RX words and TX bytes are queued when stimulus is issued.
// Negedge monitors pop the queues and compare them with what the DUT
// presents. A simple transmitter model drives tx_busy: it rises one cycle
// after each start and falls ten cycles later.

module tb_uart_word_buffer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
    logic [2:0]   fifo_count;
    logic [2:0]   byte_count;
    logic         overflow;
    logic [W-1:0] tx_word;
    logic         tx_word_valid;
    logic         tx_word_ready;
    logic         tx_busy;
    logic         tx_start;
    logic [7:0]   tx_data;

    logic         clear_b;
    logic         rx_valid_b;
    logic [7:0]   rx_byte_b;
    logic [7:0]   word_out_b;
    logic         word_valid_b;
    logic         word_ready_b;
    logic [1:0]   fifo_count_b;
    logic [0:0]   byte_count_b;
    logic         overflow_b;
    logic         tx_word_ready_b;
    logic         tx_start_b;
    logic [7:0]   tx_data_b;

    int checks = 0;
    int passes = 0;
    int start_count = 0;
    logic prev_start = 1'b0;

    logic [W-1:0] rx_exp [$];
    logic [7:0]   tx_exp [$];

    uart_word_buffer #(.NUM_BYTES(4), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .fifo_count(fifo_count), .byte_count(byte_count), .overflow(overflow),
        .tx_word(tx_word), .tx_word_valid(tx_word_valid), .tx_word_ready(tx_word_ready),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data)
    );

    uart_word_buffer #(.NUM_BYTES(1), .DEPTH(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b),
        .rx_valid(rx_valid_b), .rx_byte(rx_byte_b),
        .word_out(word_out_b), .word_valid(word_valid_b), .word_ready(word_ready_b),
        .fifo_count(fifo_count_b), .byte_count(byte_count_b), .overflow(overflow_b),
        .tx_word(8'h00), .tx_word_valid(1'b0), .tx_word_ready(tx_word_ready_b),
        .tx_busy(1'b0), .tx_start(tx_start_b), .tx_data(tx_data_b)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one received byte.
    // Must be called one time unit after a rising edge; returns at the
    // same alignment.
    task automatic applyStimulus(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(w[8*i +: 8]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold word_ready high until the FIFO is empty or the budget expires.
    task automatic drain(input int budget);
        int n;
        n = 0;
        word_ready = 1'b1;
        while (word_valid && n < budget) begin
            tick(1);
            n++;
        end
        word_ready = 1'b0;
        checkOutput("drain_empty", {63'd0, word_valid}, 64'd0);
        checkOutput("rx_queue_empty", 64'(rx_exp.size()), 64'd0);
    endtask

    // RX monitor: every word the consumer accepts must be the next
    // expected word.
    always @(negedge clk) begin
        if (word_valid && word_ready) begin
            if (rx_exp.size() == 0) begin
                checks++;
                $display("[TB] FAIL rx_unexpected_word: got 0x%0h, expected none", word_out);
            end else begin
                checkOutput("rx_word", 64'(word_out), 64'(rx_exp.pop_front()));
            end
        end
    end

    // TX monitor.
    // Every start pulse must:
    //   - be a single cycle long,
    //   - occur while the transmitter is idle,
    //   - carry the next expected byte.
    always @(negedge clk) begin
        if (tx_start) begin
            start_count++;
            checkOutput("tx_start_while_busy", {63'd0, tx_busy}, 64'd0);
            checkOutput("tx_start_single_cycle", {63'd0, prev_start}, 64'd0);
            if (tx_exp.size() == 0) begin
                checks++;
                $display("[TB] FAIL tx_unexpected_start: got data 0x%0h, expected no start", tx_data);
            end else begin
                checkOutput("tx_data", 64'(tx_data), 64'(tx_exp.pop_front()));
            end
        end
        prev_start = tx_start;
    end

    // Transmitter busy model: busy rises one cycle after a start pulse
    // and falls ten cycles later.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int base;
        int n;

        rst_n = 1'b0; clear = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        word_ready = 1'b0; tx_word = '0; tx_word_valid = 1'b0;
        clear_b = 1'b0; rx_valid_b = 1'b0; rx_byte_b = 8'h00; word_ready_b = 1'b0;

        // Reset values.
        tick(3);
        checkOutput("rst_word_valid", {63'd0, word_valid}, 64'd0);
        checkOutput("rst_fifo_count", 64'(fifo_count), 64'd0);
        checkOutput("rst_byte_count", 64'(byte_count), 64'd0);
        checkOutput("rst_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("rst_tx_word_ready", {63'd0, tx_word_ready}, 64'd1);
        checkOutput("rst_tx_start", {63'd0, tx_start}, 64'd0);
        checkOutput("rst_tx_data", 64'(tx_data), 64'd0);
        checkOutput("rst_word_out", 64'(word_out), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Pack one word and watch the byte lanes fill.
        applyStimulus(8'h11);
        checkOutput("pack_count1", 64'(byte_count), 64'd1);
        applyStimulus(8'h22);
        checkOutput("pack_count2", 64'(byte_count), 64'd2);
        applyStimulus(8'h33);
        checkOutput("pack_count3", 64'(byte_count), 64'd3);
        checkOutput("pack_not_valid_yet", {63'd0, word_valid}, 64'd0);
        rx_exp.push_back(32'h44332211);
        applyStimulus(8'h44);
        checkOutput("pack_count0", 64'(byte_count), 64'd0);
        checkOutput("pack_word_valid", {63'd0, word_valid}, 64'd1);
        checkOutput("pack_word_out", 64'(word_out), 64'h44332211);
        checkOutput("pack_fifo_count", 64'(fifo_count), 64'd1);
        drain(10);
        checkOutput("empty_word_out", 64'(word_out), 64'd0);

        // Overflow: five words into a four-deep FIFO.
        // The fifth word is dropped.
        rx_exp.push_back(32'h04030201);
        rx_exp.push_back(32'h08070605);
        rx_exp.push_back(32'h0C0B0A09);
        rx_exp.push_back(32'h100F0E0D);
        send_word(32'h04030201);
        send_word(32'h08070605);
        send_word(32'h0C0B0A09);
        send_word(32'h100F0E0D);
        send_word(32'h14131211);
        checkOutput("ovf_fifo_count", 64'(fifo_count), 64'd4);
        checkOutput("ovf_flag", {63'd0, overflow}, 64'd1);
        checkOutput("ovf_byte_count", 64'(byte_count), 64'd0);
        drain(20);
        checkOutput("ovf_sticky", {63'd0, overflow}, 64'd1);

        // Clear with a queued word, a partial word and a same-cycle byte.
        send_word(32'hAABBCCDD);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        checkOutput("pre_clear_byte_count", 64'(byte_count), 64'd2);
        checkOutput("pre_clear_fifo_count", 64'(fifo_count), 64'd1);
        clear = 1'b1; rx_valid = 1'b1; rx_byte = 8'h99;
        tick(1);
        clear = 1'b0; rx_valid = 1'b0;
        checkOutput("clear_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("clear_fifo_count", 64'(fifo_count), 64'd0);
        checkOutput("clear_byte_count", 64'(byte_count), 64'd0);
        checkOutput("clear_word_valid", {63'd0, word_valid}, 64'd0);
        rx_exp.push_back(32'h54433221);
        send_word(32'h54433221);
        drain(10);

        // FIFO full while the last byte of a new word lands on a pop.
        rx_exp.push_back(32'hA3A2A1A0);
        rx_exp.push_back(32'hB3B2B1B0);
        rx_exp.push_back(32'hC3C2C1C0);
        rx_exp.push_back(32'hD3D2D1D0);
        rx_exp.push_back(32'hE3E2E1E0);
        send_word(32'hA3A2A1A0);
        send_word(32'hB3B2B1B0);
        send_word(32'hC3C2C1C0);
        send_word(32'hD3D2D1D0);
        applyStimulus(8'hE0);
        applyStimulus(8'hE1);
        applyStimulus(8'hE2);
        rx_valid = 1'b1; rx_byte = 8'hE3; word_ready = 1'b1;
        tick(1);
        rx_valid = 1'b0; word_ready = 1'b0;
        checkOutput("fullpop_fifo_count", 64'(fifo_count), 64'd4);
        checkOutput("fullpop_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("fullpop_head", 64'(word_out), 64'hB3B2B1B0);
        drain(20);

        // TX: serialise 0xDEADBEEF.
        base = start_count;
        tx_exp.push_back(8'hEF);
        tx_exp.push_back(8'hBE);
        tx_exp.push_back(8'hAD);
        tx_exp.push_back(8'hDE);
        tx_word = 32'hDEADBEEF; tx_word_valid = 1'b1;
        tick(1);
        tx_word_valid = 1'b0;
        checkOutput("tx_ready_low", {63'd0, tx_word_ready}, 64'd0);
        n = 0;
        while (!tx_word_ready && n < 300) begin
            tick(1);
            n++;
        end
        checkOutput("tx_ready_return", {63'd0, tx_word_ready}, 64'd1);
        checkOutput("tx_busy_at_ready", {63'd0, tx_busy}, 64'd0);
        checkOutput("tx_start_count", 64'(start_count - base), 64'd4);
        checkOutput("tx_queue_empty", 64'(tx_exp.size()), 64'd0);
        checkOutput("tx_data_hold", 64'(tx_data), 64'hDE);

        // Reset in the middle of both an RX word and a TX word.
        applyStimulus(8'h77);
        applyStimulus(8'h88);
        checkOutput("mid_byte_count", 64'(byte_count), 64'd2);
        base = start_count;
        tx_exp.push_back(8'h67);
        tx_exp.push_back(8'h45);
        tx_word = 32'h01234567; tx_word_valid = 1'b1;
        tick(1);
        tx_word_valid = 1'b0;
        n = 0;
        while (start_count < base + 2 && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("mid_two_starts", 64'(start_count - base), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_byte_count", 64'(byte_count), 64'd0);
        checkOutput("arst_tx_word_ready", {63'd0, tx_word_ready}, 64'd1);
        checkOutput("arst_tx_start", {63'd0, tx_start}, 64'd0);
        checkOutput("arst_tx_data", 64'(tx_data), 64'd0);
        checkOutput("arst_word_valid", {63'd0, word_valid}, 64'd0);
        #2 rst_n = 1'b1;
        tick(40);
        checkOutput("post_rst_no_start", 64'(start_count - base), 64'd2);
        checkOutput("post_rst_tx_queue", 64'(tx_exp.size()), 64'd0);
        checkOutput("post_rst_byte_count", 64'(byte_count), 64'd0);
        rx_exp.push_back(32'h8D7C6B5A);
        send_word(32'h8D7C6B5A);
        drain(10);

        // Single-byte, two-deep build.
        rx_valid_b = 1'b1; rx_byte_b = 8'hA5;
        tick(1);
        rx_valid_b = 1'b0;
        checkOutput("b_word_out", 64'(word_out_b), 64'hA5);
        checkOutput("b_word_valid", {63'd0, word_valid_b}, 64'd1);
        checkOutput("b_fifo_count", 64'(fifo_count_b), 64'd1);
        checkOutput("b_byte_count", 64'(byte_count_b), 64'd0);
        rx_valid_b = 1'b1; rx_byte_b = 8'h3C; clear_b = 1'b1;
        tick(1);
        rx_valid_b = 1'b0; clear_b = 1'b0;
        checkOutput("b_clear_fifo_count", 64'(fifo_count_b), 64'd0);
        checkOutput("b_clear_word_valid", {63'd0, word_valid_b}, 64'd0);
        for (int i = 1; i <= 3; i++) begin
            rx_valid_b = 1'b1; rx_byte_b = 8'(i);
            tick(1);
            rx_valid_b = 1'b0;
        end
        checkOutput("b_ovf_fifo_count", 64'(fifo_count_b), 64'd2);
        checkOutput("b_ovf_flag", {63'd0, overflow_b}, 64'd1);
        checkOutput("b_ovf_head", 64'(word_out_b), 64'h01);
        word_ready_b = 1'b1;
        tick(1);
        word_ready_b = 1'b0;
        checkOutput("b_pop_head", 64'(word_out_b), 64'h02);
        checkOutput("b_tx_idle", {63'd0, tx_word_ready_b}, 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_word_buffer.md
Name: uart_word_buffer

Overview:
- Parametrised byte-to-word packer/FIFO and word-to-byte unpacker between the UART receiver/transmitter and the encoder/decoder datapath.
- RX side packs NUM_BYTES received bytes (LSB first) into a word and queues it in a DEPTH-entry FIFO for a valid/ready consumer.
- TX side takes a word from a valid/ready producer and serialises it byte by byte to the UART transmitter, pacing on its busy flag.
- Replaces the fixed 4-byte button-driven buffer with handshaked, overflow-safe streaming in both directions.

Parameters:
- NUM_BYTES, 4, bytes per word (>=1); word width W = 8*NUM_BYTES.
- DEPTH, 4, RX word FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: empties FIFO, drops partial word, aborts TX, clears overflow.
- rx_valid  in  1  one-cycle pulse, rx_byte valid (from async_receiver RxD_data_ready).
- rx_byte  in  8  received byte.
- word_out  out  W  FIFO head word; byte k = bits [8k+7:8k], byte 0 received first.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accepts word_out when word_valid && word_ready.
- fifo_count  out  $clog2(DEPTH)+1  words stored, 0..DEPTH.
- byte_count  out  $clog2(NUM_BYTES)+1  bytes held in partial word, 0..NUM_BYTES-1.
- overflow  out  1  sticky: a completed word was dropped because FIFO full.
- tx_word  in  W  word to transmit, byte 0 sent first.
- tx_word_valid  in  1  producer offers tx_word.
- tx_word_ready  out  1  high only in TX_IDLE; word captured when valid && ready.
- tx_busy  in  1  transmitter busy (async_transmitter TxD_busy).
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_data  out  8  byte to transmit; stable from tx_start until next byte loads.

Behaviour:
- Reset (rst_n=0, async): FIFO empty, word_valid=0, fifo_count=0, byte_count=0, overflow=0, TX state TX_IDLE, tx_word_ready=1, tx_start=0, tx_data=0, word_out=0 content don't-care but driven 0 when empty.
- Reset mid-transfer: partial word and in-flight TX word discarded; no further tx_start.
- RX pack: on rx_valid, byte written to lane byte_count; byte_count increments. On the NUM_BYTES-th byte, completed word pushed in same cycle, byte_count -> 0; word_valid high next cycle (1-cycle latency).
- Push with FIFO full and no simultaneous pop: word dropped, overflow set, byte_count still -> 0. Push with FIFO full and simultaneous pop: both happen, fifo_count unchanged, no overflow.
- Pop: word_valid && word_ready advances read pointer; word_ready ignored when empty. Pointers wrap modulo DEPTH.
- NUM_BYTES=1: every rx_valid pushes a word; byte_count constant 0.
- clear: highest priority after reset; same-cycle rx_valid byte is discarded; same-cycle pop ignored; TX returns to TX_IDLE, tx_start=0.
- TX FSM:
  - TX_IDLE: tx_word_ready=1; on tx_word_valid latch tx_word into shift reg, idx=0 -> TX_WAIT_FREE.
  - TX_WAIT_FREE: when tx_busy=0, tx_data=byte idx, tx_start=1 for exactly one cycle -> TX_WAIT_BUSY.
  - TX_WAIT_BUSY: wait tx_busy=1 -> TX_WAIT_DONE. (No timeout; transmitter guarantees busy within 2 cycles of start.)
  - TX_WAIT_DONE: wait tx_busy=0; if idx=NUM_BYTES-1 -> TX_IDLE, else idx+1 -> TX_WAIT_FREE.
- Minimum gap between tx_start pulses: 3 cycles. RX and TX paths fully independent; simultaneous activity allowed.

Test Plan:
- Reset, feed rx bytes 0x11,0x22,0x33,0x44 with word_ready=0 -> byte_count 1,2,3,0; word_out=0x44332211, word_valid=1 one cycle after 4th byte, fifo_count=1.
- Feed 5 words (20 bytes) with word_ready=0, DEPTH=4 -> fifo_count=4, overflow=1, words 1-4 pop intact in order; clear -> overflow=0, fifo_count=0.
- FIFO full, 4th byte of new word arrives same cycle as pop -> fifo_count stays 4, overflow=0, new word appears at tail.
- tx_word=0xDEADBEEF, busy model rises 1 cycle after start, falls 10 later -> tx_start pulses with tx_data 0xEF,0xBE,0xAD,0xDE, each single-cycle, none while busy; tx_word_ready returns 1 after last busy fall.
- Assert rst_n=0 after 2nd TX byte and 2 bytes into RX word -> all outputs at reset values immediately; after release no tx_start, byte_count=0.
- NUM_BYTES=1, DEPTH=2 build: rx 0xA5 -> word_out=0xA5 next cycle; rx_valid and clear same cycle -> byte discarded, fifo_count=0.
